// File: rtl/xif_alu_coproc.sv
// xif_alu_coproc: CV-X-IF coprocessor with an in-order instruction queue,
// commit/kill tracking per entry and a small fixed-latency integer ALU.
// The X-IF bundles are flattened into plain ports. Only the issue, commit
// and result paths carry live logic. The other interfaces are tied off.
module xif_alu_coproc #(
  parameter logic [6:0] OPCODE  = 7'h0B,
  parameter int         DEPTH   = 4,
  parameter int         LATENCY = 2,
  parameter int         ID_W    = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // compressed interface (unused)
  input  logic            compressed_valid,
  input  logic [15:0]     compressed_instr,
  input  logic [ID_W-1:0] compressed_id,
  output logic            compressed_ready,
  output logic [31:0]     compressed_resp_instr,
  output logic            compressed_resp_accept,
  // issue interface
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_instr,
  input  logic [ID_W-1:0] issue_id,
  input  logic [31:0]     issue_rs0,
  input  logic [31:0]     issue_rs1,
  input  logic [1:0]      issue_rs_valid,
  output logic            issue_accept,
  output logic            issue_writeback,
  output logic            issue_dualwrite,
  output logic            issue_dualread,
  output logic            issue_loadstore,
  output logic            issue_ecswrite,
  output logic            issue_exc,
  // commit interface
  input  logic            commit_valid,
  input  logic [ID_W-1:0] commit_id,
  input  logic            commit_kill,
  // memory request interface (unused)
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [ID_W-1:0] mem_req_id,
  output logic [31:0]     mem_req_addr,
  output logic            mem_req_we,
  output logic [1:0]      mem_req_size,
  output logic [3:0]      mem_req_be,
  output logic [31:0]     mem_req_wdata,
  // memory result interface (ignored)
  input  logic            mem_result_valid,
  input  logic [ID_W-1:0] mem_result_id,
  input  logic [31:0]     mem_result_rdata,
  input  logic            mem_result_err,
  input  logic            mem_result_dbg,
  // result interface
  output logic            result_valid,
  input  logic            result_ready,
  output logic [ID_W-1:0] result_id,
  output logic [31:0]     result_data,
  output logic [4:0]      result_rd,
  output logic            result_we,
  output logic [5:0]      result_ecsdata,
  output logic [2:0]      result_ecswe,
  output logic            result_exc,
  output logic [5:0]      result_exccode,
  output logic            result_err,
  output logic            result_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DROP, RESP} state_t;

  // queue storage, one register set per slot so commit can update all slots
  logic            ent_valid     [DEPTH];
  logic [ID_W-1:0] ent_id        [DEPTH];
  logic [4:0]      ent_rd        [DEPTH];
  logic [2:0]      ent_funct3    [DEPTH];
  logic [31:0]     ent_rs1       [DEPTH];
  logic [31:0]     ent_rs2       [DEPTH];
  logic            ent_committed [DEPTH];
  logic            ent_killed    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [IDX_W-1:0] wr_idx, head_idx;
  logic             full, match, push, pop, new_commit_hit;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             latch;
  logic [31:0]      alu_out;

  // tie-offs for the interfaces this block does not use
  assign compressed_ready       = 1'b0;
  assign compressed_resp_instr  = 32'h0;
  assign compressed_resp_accept = 1'b0;
  assign mem_valid     = 1'b0;
  assign mem_req_id    = '0;
  assign mem_req_addr  = 32'h0;
  assign mem_req_we    = 1'b0;
  assign mem_req_size  = 2'b00;
  assign mem_req_be    = 4'h0;
  assign mem_req_wdata = 32'h0;

  logic unused_inputs;
  assign unused_inputs = ^{compressed_valid, compressed_instr, compressed_id,
                           issue_instr[24:15], mem_ready, mem_result_valid,
                           mem_result_id, mem_result_rdata, mem_result_err,
                           mem_result_dbg};

  assign wr_idx   = wr_ptr_reg[IDX_W-1:0];
  assign head_idx = rd_ptr_reg[IDX_W-1:0];
  assign full     = (wr_idx == head_idx) && (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);

  // issue decode and combinational handshake response
  assign match = issue_valid && (issue_instr[6:0] == OPCODE) &&
                 (issue_instr[31:25] == 7'd0) && (issue_instr[14:12] <= 3'b100);
  assign issue_ready     = !(match && (full || (issue_rs_valid != 2'b11)));
  assign issue_accept    = match && issue_ready;
  assign issue_writeback = issue_accept;
  assign issue_dualwrite = 1'b0;
  assign issue_dualread  = 1'b0;
  assign issue_loadstore = 1'b0;
  assign issue_ecswrite  = 1'b0;
  assign issue_exc       = 1'b0;

  assign push = issue_accept;
  assign pop  = (state_reg == DROP) || ((state_reg == RESP) && result_ready);
  // a commit arriving with the accept of the same id lands on the new entry
  assign new_commit_hit = commit_valid && (commit_id == issue_id);

  // queue pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // per-slot fill, commit/kill marking and release
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ent_valid[gi]     <= 1'b0;
        ent_id[gi]        <= '0;
        ent_rd[gi]        <= '0;
        ent_funct3[gi]    <= '0;
        ent_rs1[gi]       <= '0;
        ent_rs2[gi]       <= '0;
        ent_committed[gi] <= 1'b0;
        ent_killed[gi]    <= 1'b0;
      end else if (push && (wr_idx == IDX_W'(gi))) begin
        ent_valid[gi]     <= 1'b1;
        ent_id[gi]        <= issue_id;
        ent_rd[gi]        <= issue_instr[11:7];
        ent_funct3[gi]    <= issue_instr[14:12];
        ent_rs1[gi]       <= issue_rs0;
        ent_rs2[gi]       <= issue_rs1;
        ent_committed[gi] <= new_commit_hit;
        ent_killed[gi]    <= new_commit_hit && commit_kill;
      end else begin
        if (ent_valid[gi] && commit_valid && (ent_id[gi] == commit_id)) begin
          ent_committed[gi] <= 1'b1;
          if (commit_kill) ent_killed[gi] <= 1'b1;
        end
        if (pop && (head_idx == IDX_W'(gi))) ent_valid[gi] <= 1'b0;
      end
    end
  end

  // ALU on the head entry operands
  always_comb begin
    alu_out = 32'h0;
    case (ent_funct3[head_idx])
      3'b000:  alu_out = ent_rs1[head_idx] + ent_rs2[head_idx];
      3'b001:  alu_out = ent_rs1[head_idx] - ent_rs2[head_idx];
      3'b010:  alu_out = ent_rs1[head_idx] ^ ent_rs2[head_idx];
      3'b011:  alu_out = ($signed(ent_rs1[head_idx]) < $signed(ent_rs2[head_idx]))
                         ? ent_rs1[head_idx] : ent_rs2[head_idx];
      3'b100:  alu_out = (ent_rs1[head_idx] > ent_rs2[head_idx])
                         ? ent_rs1[head_idx] : ent_rs2[head_idx];
      default: alu_out = 32'h0;
    endcase
  end

  // head FSM state and latency counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // head FSM next state: wait for commit, then execute, drop or respond
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ent_valid[head_idx] && ent_committed[head_idx]) begin
          if (ent_killed[head_idx]) begin
            state_next = DROP;
          end else begin
            state_next = EXEC;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      EXEC: begin
        if (cnt_reg == '0) begin
          latch      = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DROP: state_next = IDLE;
      RESP: if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // result holding registers, loaded once per executed entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_id   <= '0;
      result_data <= 32'h0;
      result_rd   <= 5'd0;
      result_we   <= 1'b0;
    end else if (latch) begin
      result_id   <= ent_id[head_idx];
      result_data <= alu_out;
      result_rd   <= ent_rd[head_idx];
      result_we   <= 1'b1;
    end
  end

  assign result_valid   = (state_reg == RESP);
  assign result_ecsdata = 6'd0;
  assign result_ecswe   = 3'd0;
  assign result_exc     = 1'b0;
  assign result_exccode = 6'd0;
  assign result_err     = 1'b0;
  assign result_dbg     = 1'b0;

endmodule
